// File: rtl/fifo_flag_gen.sv
// FIFO status stage: turns the wrapped pointer difference plus a direction state into registered flags, level and grants.
// Registered flags update on the same edge as the pointers; grants are combinational; errors are sticky until clr_err.
module fifo_flag_gen #(
    parameter int A_LENGTH  = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [A_LENGTH-1:0] ptr_diff,
    input  logic                clr_err,
    output logic                wr_allow,
    output logic                rd_allow,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [A_LENGTH:0]   fill_level,
    output logic                overflow,
    output logic                underflow,
    output logic                sync_err
);

    localparam int               DEPTH   = 1 << A_LENGTH;
    localparam logic [A_LENGTH:0] DEPTH_V = DEPTH[A_LENGTH:0];
    localparam logic [A_LENGTH:0] AF_V    = AF_THRESH[A_LENGTH:0];
    localparam logic [A_LENGTH:0] AE_V    = AE_THRESH[A_LENGTH:0];

    typedef enum logic [1:0] {S_EMPTY, S_NORM, S_FULL} state_t;

    state_t              state_q, state_d;
    logic [A_LENGTH:0]   fill_level_q, fill_level_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                almost_full_q, almost_full_d;
    logic                almost_empty_q, almost_empty_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                sync_err_q, sync_err_d;

    logic [A_LENGTH:0]   occ;
    logic [A_LENGTH:0]   nocc;
    logic                wa;
    logic                ra;
    logic                sync_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_EMPTY;
            fill_level_q   <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            sync_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            fill_level_q   <= fill_level_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            sync_err_q     <= sync_err_d;
        end
    end

    // A zero difference is ambiguous; the state register says whether it means full or empty.
    always_comb begin
        occ = '0;
        if (ptr_diff != '0) begin
            occ = {1'b0, ptr_diff};
        end else if (state_q == S_FULL) begin
            occ = DEPTH_V;
        end
        wa   = wr_en & wr_allow;
        ra   = rd_en & rd_allow;
        nocc = occ + {{A_LENGTH{1'b0}}, wa} - {{A_LENGTH{1'b0}}, ra};

        state_d = S_NORM;
        if (nocc == '0) begin
            state_d = S_EMPTY;
        end else if (nocc == DEPTH_V) begin
            state_d = S_FULL;
        end
    end

    always_comb begin
        wr_allow = ~full_q | rd_en;
        rd_allow = ~empty_q;

        fill_level_d   = nocc;
        full_d         = (nocc == DEPTH_V);
        empty_d        = (nocc == '0);
        almost_full_d  = (nocc >= AF_V);
        almost_empty_d = (nocc <= AE_V);

        sync_evt = (state_q == S_NORM) ? (ptr_diff != fill_level_q[A_LENGTH-1:0])
                                       : (ptr_diff != '0);
        // A new event on the same edge as clr_err keeps the flag set.
        overflow_d  = (wr_en & ~wr_allow) | (overflow_q  & ~clr_err);
        underflow_d = (rd_en & ~rd_allow) | (underflow_q & ~clr_err);
        sync_err_d  = sync_evt            | (sync_err_q  & ~clr_err);
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign fill_level   = fill_level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign sync_err     = sync_err_q;

endmodule
